// File: rtl/mul_host_if.sv
// Bus bundle around mul_host_ctrl: upstream pairs, operand/result FIFOs,
// multiplier control and the downstream result port.
interface mul_host_if #(parameter int DW = 32);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_last;
  logic          fifo_wr0;
  logic          fifo_wr1;
  logic [DW-1:0] fifo_din0;
  logic [DW-1:0] fifo_din1;
  logic [3:0]    fifo_data_count0;
  logic [3:0]    fifo_data_count1;
  logic          res_rd;
  logic [DW-1:0] res_dout;
  logic [3:0]    res_data_count;
  logic          op_start;
  logic          op_clear;
  logic          op_done;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          err;

  modport master (
    input  in_valid, in_a, in_b, in_last, fifo_data_count0, fifo_data_count1,
           res_dout, res_data_count, op_done, out_ready,
    output in_ready, fifo_wr0, fifo_wr1, fifo_din0, fifo_din1, res_rd,
           op_start, op_clear, out_valid, out_data, busy, err
  );

  modport slave (
    output in_valid, in_a, in_b, in_last, fifo_data_count0, fifo_data_count1,
           res_dout, res_data_count, op_done, out_ready,
    input  in_ready, fifo_wr0, fifo_wr1, fifo_din0, fifo_din1, res_rd,
           op_start, op_clear, out_valid, out_data, busy, err
  );
endinterface

// File: rtl/mul_host_ctrl.sv
// Host sequencer for the multiplier FIFO trio: load a batch, run, drain results, clear.
// Optional RUN watchdog enabled by defining MUL_HOST_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for the first pair of a batch
// LOAD  | pushing operand pairs into the two operand FIFOs
// RUN   | op_start held until the multiplier reports op_done
// DRAIN | popping dcnt results into the output register
// CLEAR | one-cycle op_clear, batch counter reset
module mul_host_ctrl #(
  parameter int DW             = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int BATCH_MAX      = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       reset,
  mul_host_if.master bus
);
  localparam int            CW    = $clog2(BATCH_MAX + 1);
  localparam logic [3:0]    DEPTH = 4'(FIFO_DEPTH);
  localparam logic [CW-1:0] BMAX  = CW'(BATCH_MAX);
  localparam logic [CW-1:0] BLAST = CW'(BATCH_MAX - 1);

  if (BATCH_MAX < 1 || BATCH_MAX > FIFO_DEPTH || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_param_check
    $error("mul_host_ctrl: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, CLEAR} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] pcnt, dcnt;
  logic          rd_inflight;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic          in_ready_c, push, res_rd_c, op_start_c, op_clear_c;
  logic          out_room, wd_expired;

  assign out_room = !out_valid_q || bus.out_ready;

`ifdef MUL_HOST_TIMEOUT_EN
  localparam logic [9:0] WD_INIT = 10'(TIMEOUT_CYCLES - 1);
  logic [9:0] wd;
  logic       err_q;

  assign wd_expired = (wd == 10'd0);

  // Down-counter reloaded outside RUN; terminal count on the last allowed RUN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd    <= WD_INIT;
      err_q <= 1'b0;
    end else begin
      if (state == RUN) wd <= wd - 10'd1;
      else              wd <= WD_INIT;
      if (state == RUN && !bus.op_done && wd_expired) err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign wd_expired = 1'b0;
  assign bus.err    = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    push       = 1'b0;
    res_rd_c   = 1'b0;
    op_start_c = 1'b0;
    op_clear_c = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = LOAD;
      LOAD: begin
        in_ready_c = (bus.fifo_data_count0 < DEPTH) && (bus.fifo_data_count1 < DEPTH) && (pcnt < BMAX);
        if (bus.in_valid && in_ready_c) begin
          push = 1'b1;
          if (bus.in_last || pcnt == BLAST) state_nxt = RUN;
        end
      end
      RUN: begin
        op_start_c = 1'b1;
        if (bus.op_done)     state_nxt = DRAIN;
        else if (wd_expired) state_nxt = CLEAR;
      end
      DRAIN: begin
        res_rd_c = (bus.res_data_count != 4'd0) && (dcnt != '0) && out_room && !rd_inflight;
        if (dcnt == '0 && !rd_inflight && out_valid_q && bus.out_ready) state_nxt = CLEAR;
      end
      CLEAR: begin
        op_clear_c = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pcnt        <= '0;
      dcnt        <= '0;
      rd_inflight <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state       <= state_nxt;
      rd_inflight <= res_rd_c;
      if (push)                 pcnt <= pcnt + CW'(1);
      else if (state == CLEAR)  pcnt <= '0;
      // Result lands one cycle after the pop; the register was already free when it was issued.
      if (rd_inflight) begin
        out_data_q  <= bus.res_dout;
        out_valid_q <= 1'b1;
        dcnt        <= dcnt - CW'(1);
      end else begin
        if (bus.out_ready) out_valid_q <= 1'b0;
        if (state == RUN && bus.op_done) dcnt <= pcnt;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.fifo_wr0  = push;
  assign bus.fifo_wr1  = push;
  assign bus.fifo_din0 = push ? bus.in_a : '0;
  assign bus.fifo_din1 = push ? bus.in_b : '0;
  assign bus.res_rd    = res_rd_c;
  assign bus.op_start  = op_start_c;
  assign bus.op_clear  = op_clear_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mul_host_ctrl.sv
// Bench for mul_host_ctrl: FIFO/multiplier model, vector table and a result scoreboard.
module tb_mul_host_ctrl;
  localparam int DW = 32;
`ifdef MUL_HOST_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 1023;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mul_host_if #(.DW(DW)) bus ();
  mul_host_ctrl #(.DW(DW), .FIFO_DEPTH(8), .BATCH_MAX(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        last;
    logic [31:0] prod;
  } vec_t;

  vec_t        vecs [14];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q [$];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] resq [$];
  int          n_push = 0, n_start = 0, n_clear = 0, n_out = 0;
  bit          bp_chk = 0, stall_chk = 0, force_full = 0, mul_hang = 0;
  logic [31:0] stall_exp = '0;
  int          st_cnt = 0;
  logic [3:0]  n0 = '0, n1 = '0, nr = '0;

  assign bus.fifo_data_count0 = force_full ? 4'd8 : n0;
  assign bus.fifo_data_count1 = n1;
  assign bus.res_data_count   = nr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO trio and multiplier: op_done during the 10th op_start cycle.
  logic        s_wr0, s_wr1, s_start, s_done, s_rd, s_clear, s_reset;
  logic [31:0] s_din0, s_din1, ta, tb;
  always @(posedge clk) begin
    s_wr0 = bus.fifo_wr0;   s_wr1 = bus.fifo_wr1;
    s_din0 = bus.fifo_din0; s_din1 = bus.fifo_din1;
    s_start = bus.op_start; s_done = bus.op_done;
    s_rd = bus.res_rd;      s_clear = bus.op_clear;
    s_reset = reset;
    #1;
    if (s_reset) begin
      q0.delete(); q1.delete(); resq.delete();
      st_cnt = 0;
      bus.res_dout = '0;
    end else begin
      if (s_wr0) q0.push_back(s_din0);
      if (s_wr1) q1.push_back(s_din1);
      if (s_start && s_done) begin
        while (q0.size() > 0 && q1.size() > 0) begin
          ta = q0.pop_front();
          tb = q1.pop_front();
          resq.push_back(ta * tb);
        end
      end
      if (s_start) st_cnt++;
      if (s_rd && resq.size() > 0) bus.res_dout = resq.pop_front();
      if (s_clear) begin
        resq.delete(); q0.delete(); q1.delete();
        st_cnt = 0;
      end
    end
    bus.op_done = !mul_hang && (st_cnt == 9);
    n0 = 4'(q0.size());
    n1 = 4'(q1.size());
    nr = 4'(resq.size());
  end

  // Monitor and scoreboard, sampling pre-edge values.
  always @(posedge clk) begin
    if (!reset) begin
      if (bus.fifo_wr0) begin
        n_push++;
        chk("push_din0", bus.fifo_din0, bus.in_a);
        chk("push_din1", bus.fifo_din1, bus.in_b);
        chk("push_wr1", {31'b0, bus.fifo_wr1}, 32'd1);
      end
      if (bus.op_start) n_start++;
      if (bus.op_clear) n_clear++;
      if (bp_chk) begin
        chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("bp_wr0", {31'b0, bus.fifo_wr0}, 32'd0);
      end
      if (stall_chk) begin
        chk("stall_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("stall_data", bus.out_data, stall_exp);
        chk("stall_rd", {31'b0, bus.res_rd}, 32'd0);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_extra: got %0h expected no result", bus.out_data);
        end else begin
          chk("sb_data", bus.out_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_pair(input vec_t v, input bit track);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = v.a;
    bus.in_b     = v.b;
    bus.in_last  = v.last;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      if (bus.in_ready) begin
        done = 1'b1;
        if (track) exp_q.push_back(v.prod);
      end
    end
    #1;
    bus.in_valid = 1'b0;
    chk("send_handshake", {31'b0, done}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (!bus.busy) ok = 1'b1;
    end
    chk(name, {31'b0, ok}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  int b_push, b_start, b_clear, b_out, got;
  bit seen;

  initial begin
    vecs[0]  = '{32'd7,          32'd6,          1'b1, 32'd42};
    vecs[1]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF};
    vecs[2]  = '{32'd3,          32'd5,          1'b0, 32'd15};
    vecs[3]  = '{32'd0,          32'd123,        1'b0, 32'd0};
    vecs[4]  = '{32'd10000,      32'd10000,      1'b0, 32'h05F5_E100};
    vecs[5]  = '{32'd2,          32'h8000_0000,  1'b0, 32'd0};
    vecs[6]  = '{32'h0000_FFFF,  32'h0000_FFFF,  1'b0, 32'hFFFE_0001};
    vecs[7]  = '{32'd12,         32'd12,         1'b0, 32'd144};
    vecs[8]  = '{32'd1,          32'd1,          1'b0, 32'd1};
    vecs[9]  = '{32'd100,        32'd3,          1'b0, 32'd300};
    vecs[10] = '{32'd4,          32'd4,          1'b0, 32'd16};
    vecs[11] = '{32'd9,          32'd9,          1'b1, 32'd81};
    vecs[12] = '{32'd5,          32'd5,          1'b0, 32'd25};
    vecs[13] = '{32'd6,          32'd7,          1'b1, 32'd42};

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_last = 1'b0;
    bus.out_ready = 1'b1; bus.op_done = 1'b0; bus.res_dout = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'b0, bus.in_ready},  32'd0);
    chk("rst_wr0",       {31'b0, bus.fifo_wr0},  32'd0);
    chk("rst_din0",      bus.fifo_din0,          32'd0);
    chk("rst_res_rd",    {31'b0, bus.res_rd},    32'd0);
    chk("rst_op_start",  {31'b0, bus.op_start},  32'd0);
    chk("rst_op_clear",  {31'b0, bus.op_clear},  32'd0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_data",  bus.out_data,           32'd0);
    chk("rst_busy",      {31'b0, bus.busy},      32'd0);
    chk("rst_err",       {31'b0, bus.err},       32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single pair
    b_push = n_push; b_start = n_start; b_clear = n_clear; b_out = n_out;
    send_pair(vecs[0], 1'b1);
    chk("single_in_run", {31'b0, bus.op_start}, 32'd1);
    wait_idle("single_idle");
    chk("single_pushes", n_push - b_push,   1);
    chk("single_start",  n_start - b_start, 10);
    chk("single_clear",  n_clear - b_clear, 1);
    chk("single_outs",   n_out - b_out,     1);
    chk("single_busy",   {31'b0, bus.busy}, 32'd0);

    // Full batch of BATCH_MAX without in_last; in_valid held in RUN is ignored
    b_push = n_push; b_start = n_start; b_clear = n_clear; b_out = n_out;
    for (int i = 1; i <= 8; i++) send_pair(vecs[i], 1'b1);
    chk("batch_in_run", {31'b0, bus.op_start}, 32'd1);
    bus.in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("batch_pushes", n_push - b_push, 8);
    wait_idle("batch_idle");
    chk("batch_outs",  n_out - b_out,     8);
    chk("batch_start", n_start - b_start, 10);
    chk("batch_clear", n_clear - b_clear, 1);
    chk("batch_dcnt",  32'(dut.dcnt),     32'd0);

    // Operand FIFO full for 5 cycles mid-LOAD
    b_push = n_push; b_out = n_out;
    send_pair(vecs[9], 1'b1);
    bus.in_a = vecs[10].a; bus.in_b = vecs[10].b; bus.in_last = vecs[10].last;
    bus.in_valid = 1'b1;
    force_full = 1'b1;
    bp_chk = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    force_full = 1'b0;
    bp_chk = 1'b0;
    send_pair(vecs[10], 1'b1);
    send_pair(vecs[11], 1'b1);
    wait_idle("bp_idle");
    chk("bp_pushes", n_push - b_push, 3);
    chk("bp_outs",   n_out - b_out,   3);

    // Downstream stall for 6 cycles in DRAIN
    b_out = n_out;
    bus.out_ready = 1'b0;
    send_pair(vecs[12], 1'b1);
    send_pair(vecs[13], 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("stall_first_valid", {31'b0, seen}, 32'd1);
    stall_exp = vecs[12].prod;
    stall_chk = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    stall_chk = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle("stall_idle");
    chk("stall_outs", n_out - b_out, 2);

    // Reset while in RUN
    mul_hang = 1'b1;
    send_pair(vecs[0], 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rrun_in_run", {31'b0, bus.op_start}, 32'd1);
    b_clear = n_clear;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rrun_busy",      {31'b0, bus.busy},      32'd0);
    chk("rrun_op_start",  {31'b0, bus.op_start},  32'd0);
    chk("rrun_op_clear",  {31'b0, bus.op_clear},  32'd0);
    chk("rrun_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rrun_out_data",  bus.out_data,           32'd0);
    chk("rrun_in_ready",  {31'b0, bus.in_ready},  32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rrun_no_clear", n_clear - b_clear, 0);
    mul_hang = 1'b0;

`ifdef MUL_HOST_TIMEOUT_EN
    // Watchdog: op_done never arrives
    mul_hang = 1'b1;
    b_out = n_out;
    got = -1;
    send_pair(vecs[0], 1'b0);
    for (int i = 0; i < 100 && got < 0; i++) begin
      @(posedge clk);
      if (bus.op_clear) got = i;
    end
    chk("to_clear_cycle", got, 20);
    #1;
    chk("to_err", {31'b0, bus.err}, 32'd1);
    wait_idle("to_idle");
    chk("to_no_out", n_out - b_out, 0);
    chk("to_err_sticky", {31'b0, bus.err}, 32'd1);
    mul_hang = 1'b0;
`else
    chk("err_tied_low", {31'b0, bus.err}, 32'd0);
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
